// File: rtl/huc6261_cp_loader_if.sv
// Signal bundle between the CP loader, its controller/word source and the palette bus.
interface huc6261_cp_loader_if;
    logic        CE;
    logic        START;
    logic [8:0]  BASE;
    logic [9:0]  COUNT;
    logic        ABORT;
    logic [15:0] SRC_DATA;
    logic        SRC_VALID;
    logic        SRC_READY;
    logic        BUSY;
    logic        DONE;
    logic [8:0]  ADDR;
    logic        CSn;
    logic        WRn;
    logic        RDn;
    logic        A2;
    logic [15:0] DO;

    modport master (
        output CE, START, BASE, COUNT, ABORT, SRC_DATA, SRC_VALID,
        input  SRC_READY, BUSY, DONE, ADDR, CSn, WRn, RDn, A2, DO
    );

    modport slave (
        input  CE, START, BASE, COUNT, ABORT, SRC_DATA, SRC_VALID,
        output SRC_READY, BUSY, DONE, ADDR, CSn, WRn, RDn, A2, DO
    );
endinterface

// File: rtl/huc6261_cp_loader.sv
// Uploads a block of palette words through the HuC6261 address/data register pair,
// separating every bus write with a fixed number of idle clock-enabled cycles.
module huc6261_cp_loader #(
    parameter int GAP_CYCLES = 2
) (
    input  logic               CLK,
    input  logic               RES,
    huc6261_cp_loader_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, SEL_CPA, WR_CPA, SEL_CPD, WAIT_DATA, WR_DATA, GAP, FIN
    } state_t;

    localparam logic [2:0] GAP_LAST = 3'(GAP_CYCLES - 1);

    state_t      r_state;
    state_t      r_ret;
    logic [2:0]  r_gap;
    logic [8:0]  r_addr;
    logic [9:0]  r_remain;
    logic        r_csn;
    logic        r_wrn;
    logic        r_a2;
    logic        r_done;
    logic [15:0] r_do;
    state_t      w_gap_target;

    // An abort seen during a gap redirects the pending return to FIN.
    assign w_gap_target  = bus.ABORT ? FIN : r_ret;

    assign bus.SRC_READY = (r_state == WAIT_DATA) && !bus.ABORT;
    assign bus.BUSY      = (r_state != IDLE) && (r_state != FIN);
    assign bus.DONE      = r_done;
    assign bus.ADDR      = r_addr;
    assign bus.CSn       = r_csn;
    assign bus.WRn       = r_wrn;
    assign bus.RDn       = 1'b1;
    assign bus.A2        = r_a2;
    assign bus.DO        = r_do;

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            r_state  <= IDLE;
            r_ret    <= IDLE;
            r_gap    <= '0;
            r_addr   <= '0;
            r_remain <= '0;
            r_csn    <= 1'b1;
            r_wrn    <= 1'b1;
            r_a2     <= 1'b0;
            r_do     <= '0;
            r_done   <= 1'b0;
        end else if (bus.CE) begin
            case (r_state)
                IDLE: begin
                    if (bus.START) begin
                        if (bus.COUNT != '0) begin
                            r_addr   <= bus.BASE;
                            r_remain <= bus.COUNT;
                            r_csn    <= 1'b0;
                            r_wrn    <= 1'b0;
                            r_a2     <= 1'b0;
                            r_do     <= 16'h0001;
                            r_state  <= SEL_CPA;
                        end else begin
                            r_done   <= 1'b1;
                            r_state  <= FIN;
                        end
                    end
                end

                // Each write state is exactly one strobe cycle, always followed by a gap.
                SEL_CPA, WR_CPA, SEL_CPD, WR_DATA: begin
                    r_csn   <= 1'b1;
                    r_wrn   <= 1'b1;
                    r_gap   <= GAP_LAST;
                    r_state <= GAP;
                    if (bus.ABORT) begin
                        r_ret <= FIN;
                    end else begin
                        case (r_state)
                            SEL_CPA: r_ret <= WR_CPA;
                            WR_CPA:  r_ret <= SEL_CPD;
                            SEL_CPD: r_ret <= WAIT_DATA;
                            default: r_ret <= (r_remain > 10'd1) ? WAIT_DATA : FIN;
                        endcase
                    end
                    if (r_state == WR_DATA) begin
                        r_addr   <= r_addr + 9'd1;
                        r_remain <= r_remain - 10'd1;
                    end
                end

                WAIT_DATA: begin
                    if (bus.ABORT) begin
                        r_done  <= 1'b1;
                        r_state <= FIN;
                    end else if (bus.SRC_VALID) begin
                        r_csn   <= 1'b0;
                        r_wrn   <= 1'b0;
                        r_a2    <= 1'b1;
                        r_do    <= bus.SRC_DATA;
                        r_state <= WR_DATA;
                    end
                end

                GAP: begin
                    if (r_gap != '0) begin
                        r_gap <= r_gap - 3'd1;
                        if (bus.ABORT) r_ret <= FIN;
                    end else begin
                        r_state <= w_gap_target;
                        case (w_gap_target)
                            WR_CPA: begin
                                r_csn <= 1'b0;
                                r_wrn <= 1'b0;
                                r_a2  <= 1'b1;
                                r_do  <= {7'b0, r_addr};
                            end
                            SEL_CPD: begin
                                r_csn <= 1'b0;
                                r_wrn <= 1'b0;
                                r_a2  <= 1'b0;
                                r_do  <= 16'h0002;
                            end
                            FIN:     r_done <= 1'b1;
                            default: ;
                        endcase
                    end
                end

                FIN: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end

                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_huc6261_cp_loader.sv
// Table-driven plus randomized bench for huc6261_cp_loader with a transaction-level bus model.
module tb_huc6261_cp_loader;
    localparam int G = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    huc6261_cp_loader_if bus();
    huc6261_cp_loader #(.GAP_CYCLES(G)) dut (.CLK(clk), .RES(rst), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;

    // Observed bus writes and events, counted in clock-enabled cycles.
    logic        mon_a2[$];
    logic [15:0] mon_do[$];
    logic [8:0]  mon_addr[$];
    int          mon_cyc[$];
    int          cyc, done_cnt, done_cyc, busy_cnt, rdn_bad, strobe_bad;
    int          stall_seen, stall_bad;
    bit          stall_on, last_hs, ce_rand;
    int          vmode;
    logic [15:0] src_q[$];
    logic [15:0] sent[$];

    typedef struct {
        logic [8:0] base;
        logic [9:0] count;
        int         vmode;
        bit         cerand;
        int         abort_after;
        int         exp_strobes;
        logic [8:0] exp_addr;
    } vec_t;
    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        mon_a2.delete(); mon_do.delete(); mon_addr.delete(); mon_cyc.delete();
        cyc = 0; done_cnt = 0; done_cyc = -1; busy_cnt = 0; rdn_bad = 0; strobe_bad = 0;
        stall_seen = 0; stall_bad = 0;
    endtask

    task automatic sample();
        last_hs = 1'b0;
        if (bus.RDn !== 1'b1) rdn_bad++;
        if (bus.CSn !== bus.WRn) strobe_bad++;
        if (bus.CE === 1'b1) begin
            if (bus.CSn === 1'b0 && bus.WRn === 1'b0) begin
                mon_a2.push_back(bus.A2);
                mon_do.push_back(bus.DO);
                mon_addr.push_back(bus.ADDR);
                mon_cyc.push_back(cyc);
            end
            if (bus.DONE === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (bus.BUSY === 1'b1) busy_cnt++;
            if (bus.SRC_VALID === 1'b1 && bus.SRC_READY === 1'b1) last_hs = 1'b1;
            if (stall_on && stall_seen > 0 && stall_seen < 10 &&
                (bus.SRC_READY !== 1'b1 || bus.CSn !== 1'b1)) stall_bad++;
            if (stall_on && bus.SRC_READY === 1'b1 && bus.SRC_VALID === 1'b0) stall_seen++;
            cyc++;
        end
    endtask

    task automatic step();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        if (last_hs && src_q.size() > 0) src_q.delete(0);
        bus.START = 1'b0;
        bus.ABORT = 1'b0;
        bus.CE    = ce_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        case (vmode)
            0:       bus.SRC_VALID = (src_q.size() > 0);
            1:       bus.SRC_VALID = (src_q.size() > 0) && ($urandom_range(0, 1) == 1);
            2:       bus.SRC_VALID = (src_q.size() > 0) && (stall_seen >= 10);
            default: bus.SRC_VALID = 1'b0;
        endcase
        bus.SRC_DATA = (src_q.size() > 0) ? src_q[0] : 16'h0;
    endtask

    task automatic start_up(input logic [8:0] base, input logic [9:0] count, input int pat);
        logic [15:0] w;
        clear_mon();
        stall_on = (vmode == 2);
        src_q.delete();
        sent.delete();
        for (int i = 0; i < int'(count); i++) begin
            w = (pat == 0) ? 16'(16'h1111 * (i + 1)) : 16'($urandom);
            src_q.push_back(w);
            sent.push_back(w);
        end
        bus.BASE = base; bus.COUNT = count; bus.START = 1'b1; bus.CE = 1'b1;
        bus.ABORT = 1'b0; bus.SRC_VALID = 1'b0;
        step();
    endtask

    task automatic wait_done(input int budget, input int abort_after);
        int  n = 0;
        bit  ab = 1'b0;
        while (done_cnt == 0 && n < budget) begin
            if (abort_after > 0 && !ab && mon_a2.size() >= 3 + abort_after) begin
                bus.ABORT = 1'b1;
                bus.CE    = 1'b1;
                ab        = 1'b1;
            end
            step();
            n++;
        end
        if (done_cnt == 0) chk("done_timeout", 0, 1);
        repeat (3) step();
    endtask

    // Expected bus traffic derived from the upload's base address and word list.
    task automatic check_run(input string tag, input logic [8:0] base, input logic [9:0] count,
                             input int vm, input int exp_strobes, input logic [8:0] exp_addr);
        logic        ea2;
        logic [15:0] edo;
        logic [8:0]  eaddr;
        int          d, gap_bad = 0;
        chk({tag, ".strobes"}, mon_a2.size(), exp_strobes);
        for (int i = 0; i < mon_a2.size() && i < exp_strobes; i++) begin
            if (i == 0)      begin ea2 = 1'b0; edo = 16'h0001; end
            else if (i == 1) begin ea2 = 1'b1; edo = {7'b0, base}; end
            else if (i == 2) begin ea2 = 1'b0; edo = 16'h0002; end
            else             begin ea2 = 1'b1; edo = sent[i - 3]; end
            eaddr = (i < 3) ? base : 9'(base + 9'(i - 3));
            chk($sformatf("%s.wr%0d", tag, i), {15'b0, mon_a2[i], mon_do[i]}, {15'b0, ea2, edo});
            chk($sformatf("%s.addr%0d", tag, i), mon_addr[i], eaddr);
            if (i > 0) begin
                d = mon_cyc[i] - mon_cyc[i - 1];
                if (i <= 2) begin
                    if (d != G + 1) gap_bad++;
                end else if (vm == 0) begin
                    if (d != G + 2) gap_bad++;
                end else if (vm == 2 && i == 3) begin
                    if (d != G + 12) gap_bad++;
                end else if (d < G + 2) gap_bad++;
            end
        end
        chk({tag, ".done_pulses"}, done_cnt, 1);
        if (count != 0 && mon_cyc.size() > 0) chk({tag, ".first_strobe_cyc"}, mon_cyc[0], 1);
        if (count == 0) begin
            chk({tag, ".done_cyc"}, done_cyc, 1);
            chk({tag, ".busy_cycles"}, busy_cnt, 0);
        end
        chk({tag, ".gap_bad"}, gap_bad, 0);
        chk({tag, ".final_addr"}, bus.ADDR, exp_addr);
        chk({tag, ".busy_end"}, bus.BUSY, 0);
        chk({tag, ".rdn_strobe"}, rdn_bad + strobe_bad, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] rb;
        logic [9:0] rc;
        int         ra, n;
        ce_rand = 1'b0; vmode = 0; stall_on = 1'b0;
        bus.CE = 1'b1; bus.START = 1'b0; bus.BASE = '0; bus.COUNT = '0;
        bus.ABORT = 1'b0; bus.SRC_DATA = '0; bus.SRC_VALID = 1'b0;
        clear_mon();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.outputs",
            {bus.CSn, bus.WRn, bus.RDn, bus.A2, bus.BUSY, bus.DONE, bus.SRC_READY},
            7'b1110000);
        chk("reset.do_addr", {bus.DO, 7'b0, bus.ADDR}, 32'h0);
        rst = 1'b0;
        step();

        tbl[0] = '{9'h010, 10'd3, 0, 1'b0, 0, 6, 9'h013};
        tbl[1] = '{9'h1FF, 10'd2, 0, 1'b0, 0, 5, 9'h001};
        tbl[2] = '{9'h0C3, 10'd0, 0, 1'b0, 0, 0, 9'h001};
        tbl[3] = '{9'h055, 10'd4, 0, 1'b0, 1, 4, 9'h056};
        tbl[4] = '{9'h0AA, 10'd1, 0, 1'b1, 0, 4, 9'h0AB};
        tbl[5] = '{9'h100, 10'd2, 2, 1'b0, 0, 5, 9'h102};
        for (int t = 0; t < 6; t++) begin
            vmode = tbl[t].vmode;
            ce_rand = tbl[t].cerand;
            start_up(tbl[t].base, tbl[t].count, 0);
            wait_done(3000, tbl[t].abort_after);
            check_run($sformatf("vec%0d", t), tbl[t].base, tbl[t].count, tbl[t].vmode,
                      tbl[t].exp_strobes, tbl[t].exp_addr);
            if (tbl[t].vmode == 2) begin
                chk("stall.ready_cycles", (stall_seen >= 10), 1);
                chk("stall.bad", stall_bad, 0);
            end
        end
        ce_rand = 1'b0;

        // Randomized uploads with random valid, clock enable and occasional abort.
        for (int r = 0; r < 8; r++) begin
            rb = 9'($urandom);
            rc = 10'($urandom_range(1, 5));
            ra = (rc > 1 && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, int'(rc) - 1)) : 0;
            vmode = 1; ce_rand = 1'b1;
            start_up(rb, rc, 1);
            wait_done(3000, ra);
            check_run($sformatf("rnd%0d", r), rb, rc, 1,
                      (ra > 0) ? 3 + ra : 3 + int'(rc),
                      (ra > 0) ? 9'(rb + 9'(ra)) : 9'(rb + rc[8:0]));
        end
        ce_rand = 1'b0;

        // Abort coinciding with an offered word in WAIT_DATA.
        vmode = 3;
        start_up(9'h020, 10'd2, 0);
        n = 0;
        while (bus.SRC_READY !== 1'b1 && n < 100) begin step(); n++; end
        chk("abort_hs.reached_wait", bus.SRC_READY, 1);
        bus.ABORT = 1'b1; bus.SRC_VALID = 1'b1; bus.CE = 1'b1;
        #1;
        chk("abort_hs.ready_forced_low", bus.SRC_READY, 0);
        step();
        wait_done(100, 0);
        chk("abort_hs.strobes", mon_a2.size(), 3);
        chk("abort_hs.done_pulses", done_cnt, 1);
        chk("abort_hs.words_left", src_q.size(), 2);

        // Reset asserted while a data strobe is on the bus.
        vmode = 0;
        start_up(9'h040, 10'd2, 0);
        n = 0;
        while (!(bus.CSn === 1'b0 && bus.A2 === 1'b1 && mon_a2.size() >= 3) && n < 100) begin
            step(); n++;
        end
        chk("rst_mid.reached_data_strobe", {bus.CSn, bus.A2}, 2'b01);
        #2;
        rst = 1'b1;
        bus.START = 1'b1; bus.BASE = 9'h001; bus.COUNT = 10'd3;
        #1;
        chk("rst_mid.strobes_released", {bus.CSn, bus.WRn}, 2'b11);
        chk("rst_mid.outputs", {bus.A2, bus.BUSY, bus.DONE, bus.SRC_READY, bus.DO, bus.ADDR}, 0);
        vmode = 3;
        for (int k = 0; k < 3; k++) begin
            step();
            bus.START = 1'b1;
        end
        bus.START = 1'b0;
        rst = 1'b0;
        clear_mon();
        repeat (10) step();
        chk("rst_mid.no_writes_after", mon_a2.size(), 0);
        chk("rst_mid.idle_after", busy_cnt + done_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
